// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with registered control
// strobes, an illegal-opcode pulse and a retired-instruction counter.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        aluSrc,
  output logic [2:0]  aluOp,
  output logic [1:0]  pcSrc,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100
  } state_e;

  typedef enum logic [2:0] {ClsR, ClsAddi, ClsLw, ClsSw, ClsBeq, ClsJ} cls_e;

  localparam logic [2:0] AluNop = 3'b000;
  localparam logic [2:0] AluAdd = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluOr  = 3'b100;
  localparam logic [2:0] AluXor = 3'b101;
  localparam logic [2:0] AluJmp = 3'b111;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic        dec_legal;
  logic [2:0]  func_op;
  logic [15:0] retired_q, retired_d;

  logic        fetch_q, fetch_d, beq_q, beq_d, jmp_q, jmp_d;
  logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, reg_wr_q, reg_wr_d;
  logic        reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d, alu_src_q, alu_src_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [1:0]  pc_src_q, pc_src_d;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = ClsR;
    unique casez (opcode)
      6'b000000: dec_cls = ClsR;
      6'b00100?: dec_cls = ClsAddi;
      6'b100011: dec_cls = ClsLw;
      6'b101011: dec_cls = ClsSw;
      6'b000100: dec_cls = ClsBeq;
      6'b000010: dec_cls = ClsJ;
      default:   dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    func_op = AluNop;
    casez (func)
      6'b10000?: func_op = AluAdd;
      6'b10001?: func_op = AluSub;
      6'b100100: func_op = AluAnd;
      6'b100101: func_op = AluOr;
      6'b100110: func_op = AluXor;
      default:   func_op = AluNop;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    retired_d = retired_q;
    unique case (state_q)
      // A fetch handshake only counts once the read request is actually on the bus.
      StFetch: if (fetch_q && memReady) state_d = StDecode;
      StDecode: begin
        if (dec_legal) begin
          state_d = StExec;
          cls_d   = dec_cls;
        end else begin
          state_d = StFetch;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq, ClsJ: begin
            state_d   = StFetch;
            retired_d = retired_q + 16'd1;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        if (memReady) begin
          if (cls_q == ClsSw) begin
            state_d   = StFetch;
            retired_d = retired_q + 16'd1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        state_d   = StFetch;
        retired_d = retired_q + 16'd1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Control strobes are decoded from the next state so they are valid from a flop output
  // for the whole cycle the FSM spends in that state.
  always_comb begin
    fetch_d      = 1'b0;
    beq_d        = 1'b0;
    jmp_d        = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    reg_wr_d     = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = AluNop;
    pc_src_d     = 2'b00;
    unique case (state_d)
      StFetch: begin
        fetch_d  = 1'b1;
        mem_rd_d = 1'b1;
      end
      StExec: begin
        unique case (cls_d)
          ClsR: begin
            reg_dst_d = 1'b1;
            alu_op_d  = func_op;
          end
          ClsAddi, ClsLw, ClsSw: begin
            alu_src_d = 1'b1;
            alu_op_d  = AluAdd;
          end
          ClsBeq: begin
            alu_op_d = AluSub;
            pc_src_d = 2'b01;
            beq_d    = 1'b1;
          end
          ClsJ: begin
            alu_op_d = AluJmp;
            pc_src_d = 2'b10;
            jmp_d    = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_rd_d = (cls_d == ClsLw);
        mem_wr_d = (cls_d == ClsSw);
      end
      StWb: begin
        reg_wr_d     = 1'b1;
        mem_to_reg_d = (cls_d == ClsLw);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      cls_q        <= ClsR;
      retired_q    <= 16'd0;
      fetch_q      <= 1'b0;
      beq_q        <= 1'b0;
      jmp_q        <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= AluNop;
      pc_src_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      retired_q    <= retired_d;
      fetch_q      <= fetch_d;
      beq_q        <= beq_d;
      jmp_q        <= jmp_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      reg_wr_q     <= reg_wr_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      pc_src_q     <= pc_src_d;
    end
  end

  // Handshake- and flag-qualified writes: registered enables gated by the live acknowledge.
  assign irWrite  = fetch_q & memReady;
  assign pcWrite  = (fetch_q & memReady) | (beq_q & zero) | jmp_q;
  assign memRead  = mem_rd_q;
  assign memWrite = mem_wr_q;
  assign regWrite = reg_wr_q;
  assign regDst   = reg_dst_q;
  assign memToReg = mem_to_reg_q;
  assign aluSrc   = alu_src_q;
  assign aluOp    = alu_op_q;
  assign pcSrc    = pc_src_q;
  assign state    = state_q;
  assign illegal  = (state_q == StDecode) & ~dec_legal;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expected control vectors are queued
// as stimulus is driven and compared at the following negative clock edge.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;
  logic        pcWrite, irWrite, memRead, memWrite, regWrite, regDst, memToReg, aluSrc;
  logic [2:0]  aluOp;
  logic [1:0]  pcSrc;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  multicycle_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .func     (func),
    .zero     (zero),
    .memReady (memReady),
    .pcWrite  (pcWrite),
    .irWrite  (irWrite),
    .memRead  (memRead),
    .memWrite (memWrite),
    .regWrite (regWrite),
    .regDst   (regDst),
    .memToReg (memToReg),
    .aluSrc   (aluSrc),
    .aluOp    (aluOp),
    .pcSrc    (pcSrc),
    .state    (state),
    .illegal  (illegal),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] FMrd  = 9'h100;
  localparam logic [8:0] FMwr  = 9'h080;
  localparam logic [8:0] FIrw  = 9'h040;
  localparam logic [8:0] FPcw  = 9'h020;
  localparam logic [8:0] FRgw  = 9'h010;
  localparam logic [8:0] FRdst = 9'h008;
  localparam logic [8:0] FM2r  = 9'h004;
  localparam logic [8:0] FAsrc = 9'h002;
  localparam logic [8:0] FIll  = 9'h001;

  localparam int KR = 0, KAddi = 1, KLw = 2, KSw = 3, KBeq = 4, KJ = 5, KIll = 6;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] ret_model = 16'd0;
  logic [32:0] exp_q[$];
  string       tag_q[$];
  logic [16:0] ctl_obs;

  assign ctl_obs = {state, pcSrc, aluOp, memRead, memWrite, irWrite, pcWrite, regWrite,
                    regDst, memToReg, aluSrc, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [16:0] mk(input logic [2:0] st, input logic [1:0] ps,
                                     input logic [2:0] ao, input logic [8:0] fl);
    return {st, ps, ao, fl};
  endfunction

  // Called at posedge+1 with inputs for this cycle already driven.
  task automatic step(input string tag, input logic [16:0] ctl);
    logic [32:0] e;
    string       t;
    exp_q.push_back({ctl, ret_model});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, "/ctl"}, {15'd0, ctl_obs}, {15'd0, e[32:16]});
    check_eq({t, "/ret"}, {16'd0, retired}, {16'd0, e[15:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw, input logic [2:0] r_ao);
    logic [8:0] fl;
    logic [2:0] ao;
    logic [1:0] ps;
    opcode = op;
    func   = fn;
    zero   = z;
    for (int i = 0; i < fw; i++) begin
      memReady = 1'b0;
      step("fetch_wait", mk(3'd0, 2'b00, 3'd0, FMrd));
    end
    memReady = 1'b1;
    step("fetch", mk(3'd0, 2'b00, 3'd0, FMrd | FIrw | FPcw));
    // memReady stays high through DECODE/EXEC and must be ignored there.
    step("decode", mk(3'd1, 2'b00, 3'd0, (kind == KIll) ? FIll : 9'd0));
    if (kind == KIll) return;
    fl = 9'd0;
    ao = 3'd0;
    ps = 2'b00;
    case (kind)
      KR:             begin fl = FRdst; ao = r_ao; end
      KAddi, KLw, KSw: begin fl = FAsrc; ao = 3'd1; end
      KBeq:           begin ao = 3'd2; ps = 2'b01; fl = z ? FPcw : 9'd0; end
      KJ:             begin ao = 3'd7; ps = 2'b10; fl = FPcw; end
      default: ;
    endcase
    step("exec", mk(3'd2, ps, ao, fl));
    if (kind == KBeq || kind == KJ) begin
      ret_model++;
      return;
    end
    if (kind == KLw || kind == KSw) begin
      fl = (kind == KLw) ? FMrd : FMwr;
      for (int i = 0; i < mw; i++) begin
        memReady = 1'b0;
        step("mem_wait", mk(3'd3, 2'b00, 3'd0, fl));
      end
      memReady = 1'b1;
      step("mem", mk(3'd3, 2'b00, 3'd0, fl));
      if (kind == KSw) begin
        ret_model++;
        return;
      end
    end
    step("wb", mk(3'd4, 2'b00, 3'd0, FRgw | ((kind == KLw) ? FM2r : 9'd0)));
    ret_model++;
  endtask

  logic [5:0] r_fn[9] = '{6'b100010, 6'b100000, 6'b100001, 6'b100011, 6'b100100,
                          6'b100101, 6'b100110, 6'b100111, 6'b000000};
  logic [2:0] r_ao[9] = '{3'd2, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};

  initial begin
    memReady = 1'b1;
    opcode   = 6'h3f;
    zero     = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_ctl", {15'd0, ctl_obs}, 32'd0);
    check_eq("reset_ret", {16'd0, retired}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold", {15'd0, ctl_obs}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_instr(KR, 6'b000000, r_fn[i], 1'b1, 0, 0, r_ao[i]);
    run_instr(KAddi, 6'b001000, 6'd0, 1'b1, 2, 0, 3'd0);
    run_instr(KAddi, 6'b001001, 6'd0, 1'b0, 0, 0, 3'd0);
    run_instr(KLw, 6'b100011, 6'd0, 1'b0, 0, 3, 3'd0);
    run_instr(KLw, 6'b100011, 6'd0, 1'b1, 1, 0, 3'd0);
    run_instr(KSw, 6'b101011, 6'd0, 1'b0, 0, 0, 3'd0);
    run_instr(KSw, 6'b101011, 6'd0, 1'b1, 0, 2, 3'd0);
    run_instr(KBeq, 6'b000100, 6'd0, 1'b1, 0, 0, 3'd0);
    run_instr(KBeq, 6'b000100, 6'd0, 1'b0, 0, 0, 3'd0);
    run_instr(KJ, 6'b000010, 6'd0, 1'b0, 0, 0, 3'd0);
    run_instr(KIll, 6'b111111, 6'd0, 1'b0, 0, 0, 3'd0);
    run_instr(KIll, 6'b000001, 6'd0, 1'b0, 1, 0, 3'd0);
    run_instr(KR, 6'b000000, 6'b100100, 1'b0, 0, 0, 3'd3);

    // Reset in the middle of a stalled SW memory write.
    opcode = 6'b101011;
    zero   = 1'b0;
    memReady = 1'b1;
    step("abt_fetch", mk(3'd0, 2'b00, 3'd0, FMrd | FIrw | FPcw));
    step("abt_decode", mk(3'd1, 2'b00, 3'd0, 9'd0));
    step("abt_exec", mk(3'd2, 2'b00, 3'd1, FAsrc));
    memReady = 1'b0;
    step("abt_mem", mk(3'd3, 2'b00, 3'd0, FMwr));
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_ctl", {15'd0, ctl_obs}, 32'd0);
    check_eq("abort_ret", {16'd0, retired}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_hold", {15'd0, ctl_obs}, 32'd0);
    rst_n = 1'b1;
    ret_model = 16'd0;
    @(posedge clk);
    #1;
    check_eq("post_rst_mrd", {31'd0, memRead}, 32'd1);

    // Counter wrap: 65535 back-to-back jumps, then one more under full checking.
    opcode   = 6'b000010;
    memReady = 1'b1;
    repeat (3 * 65535) @(posedge clk);
    #1;
    check_eq("pre_wrap", {16'd0, retired}, 32'h0000_ffff);
    ret_model = 16'hffff;
    run_instr(KJ, 6'b000010, 6'd0, 1'b0, 0, 0, 3'd0);
    check_eq("wrap", {16'd0, retired}, 32'd0);
    run_instr(KR, 6'b000000, 6'b100110, 1'b0, 0, 0, 3'd5);
    check_eq("after_wrap", {16'd0, retired}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, clk, an input of width 1; all state SHALL update on its rising edge.
REQ-002 The block SHALL have reset rst_n, an input of width 1; reset is asynchronous and active-low.
REQ-003 opcode SHALL be an input of width 6 carrying IR[31:26], valid from DECODE onward.
REQ-004 func SHALL be an input of width 6 carrying IR[5:0].
REQ-005 zero SHALL be an input of width 1 carrying the ALU zero flag, sampled in EXEC.
REQ-006 memReady SHALL be an input of width 1; it is the memory handshake acknowledge.
REQ-007 pcWrite, irWrite, memRead, memWrite, regWrite, regDst, memToReg and aluSrc SHALL each be a registered output of width 1.
REQ-008 aluOp SHALL be a registered output of width 3, encoded NOP=000, ADD=001, SUB=010, AND=011, OR=100, XOR=101, JMP=111.
REQ-009 pcSrc SHALL be a registered output of width 2, encoded 00=PC+4, 01=branch target, 10=jump target.
REQ-010 state SHALL be an output of width 3 exposing the current FSM state.
REQ-011 illegal SHALL be an output of width 1, a one-cycle pulse on an undecoded opcode.
REQ-012 retired SHALL be an output of width 16 counting completed instructions.

Function
REQ-013 The FSM SHALL use states FETCH=000, DECODE=001, EXEC=010, MEM=011 and WB=100.
REQ-014 In FETCH, memRead SHALL be held at 1 until memReady=1; on that cycle irWrite=1, pcWrite=1 and pcSrc=00, and the next state SHALL be DECODE.
REQ-015 While FETCH waits for memReady=0, the FSM SHALL stay in FETCH with no PC or IR write.
REQ-016 DECODE SHALL last 1 cycle and select the next state from opcode: 000000 (R) goes to EXEC; 00100X (ADDI) goes to EXEC; 100011 (LW) goes to EXEC; 101011 (SW) goes to EXEC; 000100 (BEQ) goes to EXEC; 000010 (J) goes to EXEC.
REQ-017 In DECODE, any other opcode SHALL pulse illegal=1 and set the next state to FETCH, with retired left unchanged.
REQ-018 In EXEC for R-type, aluSrc SHALL be 0, regDst SHALL be 1, and aluOp SHALL follow func: 10000X gives ADD, 10001X gives SUB, 100100 gives AND, 100101 gives OR, 100110 gives XOR, and any other value gives NOP; the next state SHALL be WB.
REQ-019 In EXEC for ADDI, aluSrc SHALL be 1, regDst SHALL be 0 and aluOp SHALL be ADD; the next state SHALL be WB.
REQ-020 In EXEC for LW or SW, aluSrc SHALL be 1 and aluOp SHALL be ADD; the next state SHALL be MEM.
REQ-021 In EXEC for BEQ, aluOp SHALL be SUB; if zero=1, pcWrite SHALL be 1 and pcSrc SHALL be 01; the next state SHALL be FETCH and retired SHALL increment.
REQ-022 In EXEC for J, aluOp SHALL be JMP, pcWrite SHALL be 1 and pcSrc SHALL be 10; the next state SHALL be FETCH and retired SHALL increment.
REQ-023 In MEM, memRead (LW) or memWrite (SW) SHALL be held until memReady=1.
REQ-024 On MEM completion, LW SHALL go to WB and SW SHALL go to FETCH, with retired incremented for SW.
REQ-025 In WB, regWrite SHALL be 1 for 1 cycle, memToReg SHALL be 1 for LW and 0 otherwise, the next state SHALL be FETCH, and retired SHALL increment.
REQ-026 All control outputs not named for a state SHALL be 0 in that state, and pcWrite and regWrite SHALL never be asserted together.
REQ-027 retired SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 memReady asserted outside FETCH or MEM SHALL be ignored.
REQ-029 Latencies with memReady tied to 1 SHALL be: R/ADDI 4 cycles, LW 5 cycles, SW 4 cycles, BEQ/J 3 cycles.

Reset
REQ-030 While rst_n=0, the state SHALL be FETCH, every 1-bit output SHALL be 0, aluOp SHALL be 000, pcSrc SHALL be 00 and retired SHALL be 0, applied without waiting for clk.
REQ-031 Reset asserted mid-instruction, including during a pending memory handshake, SHALL abort the instruction immediately with no further write pulses.
REQ-032 After rst_n deasserts, the first active edge SHALL begin FETCH with memRead=1.

Verification
REQ-033 R-type with opcode=000000, func=100010 and memReady=1 -> states FETCH,DECODE,EXEC(aluOp=010),WB(regWrite=1), retired=1.
REQ-034 LW with memReady low for 3 cycles in MEM -> memRead held for 3+1 cycles, then WB with memToReg=1, 8 total cycles.
REQ-035 BEQ with zero=1, then BEQ with zero=0 -> pcSrc=01 with pcWrite=1 in the first EXEC, pcWrite=0 in the second, retired=2.
REQ-036 opcode=111111 -> illegal pulses in DECODE, return to FETCH, retired unchanged.
REQ-037 rst_n low during MEM of SW with memReady=0 -> memWrite drops asynchronously, state=000, retired=0.
REQ-038 Preload retired=16'hFFFF via 65535 J instructions, then one more J -> retired=0.
